// File: rtl/pc_breakpoint_unit_pkg.sv
// Shared definitions for the PC breakpoint unit: address width, debug FSM
// state encoding and the default number of breakpoint slots.
package pc_breakpoint_unit_pkg;

  localparam int ADDR_W = 12;
  localparam int DEFAULT_NUM_BP = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2,
    SKIP   = 2'd3
  } dbgState_e;

endpackage

// File: rtl/equal12bit.sv
// 12-bit equality comparator used by each breakpoint slot.
module equal12bit (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic        isEqual
);

  // Pure combinational compare.
  always_comb begin
    isEqual = (a == b);
  end

endmodule

// File: rtl/pc_breakpoint_unit.sv
// Breakpoint / halt stage: compares the fetch PC against NUM_BP programmable
// slots, stalls fetch on a hit and runs a small resume/single-step FSM.
module pc_breakpoint_unit
  import pc_breakpoint_unit_pkg::*;
#(
  parameter int NUM_BP = DEFAULT_NUM_BP,
  parameter int IDX_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bp_wr_en,
  input  logic [IDX_W-1:0]  bp_wr_idx,
  input  logic [ADDR_W-1:0] bp_wr_addr,
  input  logic              bp_wr_arm,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  input  logic              resume,
  input  logic              step,
  output logic              halt,
  output logic              hit_pulse,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [NUM_BP-1:0] bp_armed,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  hit_count
);

  logic [ADDR_W-1:0] slotAddr [NUM_BP];
  logic [NUM_BP-1:0] armed;
  logic [NUM_BP-1:0] eq;
  logic [NUM_BP-1:0] match;
  logic              anyMatch;
  logic [IDX_W-1:0]  winIdx;
  logic              newHit;
  dbgState_e         state;
  dbgState_e         stateNext;

  genvar g;
  generate
    for (g = 0; g < NUM_BP; g++) begin : genCmp
      equal12bit uEq (
        .a       (slotAddr[g]),
        .b       (pc_in),
        .isEqual (eq[g])
      );
    end
  endgenerate

  // Slot storage; a write lands at the edge, so this cycle compares old contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_BP; i++) begin
        slotAddr[i] <= '0;
      end
      armed <= '0;
    end else if (bp_wr_en) begin
      slotAddr[bp_wr_idx] <= bp_wr_addr;
      armed[bp_wr_idx]    <= bp_wr_arm;
    end
  end

  // Match vector, lowest-index priority encode and combinational stall.
  always_comb begin
    match    = armed & eq & {NUM_BP{pc_valid}};
    anyMatch = |match;
    winIdx   = '0;
    for (int unsigned i = NUM_BP; i > 0; i--) begin
      if (match[i-1]) winIdx = IDX_W'(i - 1);
    end
    newHit = (state == RUN) && anyMatch;
    halt   = newHit || (state == HALTED);
  end

  // Debug FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= stateNext;
  end

  // Next-state logic; matching only matters in RUN, so SKIP/STEP mask it.
  always_comb begin
    stateNext = state;
    unique case (state)
      RUN:    if (anyMatch) stateNext = HALTED;
      HALTED: begin
        if (step)        stateNext = STEP;
        else if (resume) stateNext = SKIP;
      end
      SKIP:   if (pc_valid) stateNext = RUN;
      STEP:   if (pc_valid) stateNext = HALTED;
      default: stateNext = RUN;
    endcase
  end

  // Registered hit reporting; only a RUN->HALTED entry counts as a hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_pulse <= 1'b0;
      hit_idx   <= '0;
      hit_count <= '0;
    end else begin
      hit_pulse <= newHit;
      if (newHit) begin
        hit_idx <= winIdx;
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
    end
  end

  // Observability outputs.
  always_comb begin
    bp_armed  = armed;
    dbg_state = state;
  end

endmodule

// File: tb/tb_pc_breakpoint_unit.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// against a behavioural model of the breakpoint rules.
module tb_pc_breakpoint_unit;

  localparam int NUM_BP = 4;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              bp_wr_en;
  logic [IDX_W-1:0]  bp_wr_idx;
  logic [11:0]       bp_wr_addr;
  logic              bp_wr_arm;
  logic [11:0]       pc_in;
  logic              pc_valid;
  logic              resume;
  logic              step;
  logic              halt;
  logic              hit_pulse;
  logic [IDX_W-1:0]  hit_idx;
  logic [NUM_BP-1:0] bp_armed;
  logic [1:0]        dbg_state;
  logic [CNT_W-1:0]  hit_count;

  pc_breakpoint_unit #(.NUM_BP(NUM_BP), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bp_wr_en   (bp_wr_en),
    .bp_wr_idx  (bp_wr_idx),
    .bp_wr_addr (bp_wr_addr),
    .bp_wr_arm  (bp_wr_arm),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .resume     (resume),
    .step       (step),
    .halt       (halt),
    .hit_pulse  (hit_pulse),
    .hit_idx    (hit_idx),
    .bp_armed   (bp_armed),
    .dbg_state  (dbg_state),
    .hit_count  (hit_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: state is 0=RUN 1=HALTED 2=STEP 3=SKIP.
  int          mAddr [NUM_BP];
  bit [NUM_BP-1:0] mArmed;
  int          mState;
  bit          mPulse;
  int          mIdx;
  int          mCount;
  logic        lastHalt;

  function automatic void modelReset();
    for (int i = 0; i < NUM_BP; i++) mAddr[i] = 0;
    mArmed = '0;
    mState = 0;
    mPulse = 0;
    mIdx   = 0;
    mCount = 0;
  endfunction

  task automatic checkRegs(input string pfx);
    checkVal({pfx, "_pulse"}, 32'(hit_pulse), 32'(mPulse));
    checkVal({pfx, "_idx"},   32'(hit_idx),   32'(mIdx));
    checkVal({pfx, "_count"}, 32'(hit_count), 32'(mCount));
    checkVal({pfx, "_state"}, 32'(dbg_state), 32'(mState));
    checkVal({pfx, "_armed"}, 32'(bp_armed),  32'(mArmed));
  endtask

  task automatic runCycle(input logic wrEn, input int wrIdx, input int wrAddr, input logic wrArm,
                          input int pc, input logic valid, input logic res, input logic stp);
    int win;
    logic expHalt;
    bp_wr_en   = wrEn;
    bp_wr_idx  = IDX_W'(wrIdx);
    bp_wr_addr = 12'(wrAddr);
    bp_wr_arm  = wrArm;
    pc_in      = 12'(pc);
    pc_valid   = valid;
    resume     = res;
    step       = stp;
    #1;
    win = -1;
    for (int i = 0; i < NUM_BP; i++)
      if (win < 0 && mArmed[i] && mAddr[i] == pc && valid) win = i;
    expHalt = (mState == 0 && win >= 0) || mState == 1;
    lastHalt = halt;
    checkVal("halt", 32'(halt), 32'(expHalt));
    checkRegs("cyc");
    @(posedge clock);
    mPulse = 0;
    case (mState)
      0: if (win >= 0) begin
           mState = 1; mPulse = 1; mIdx = win;
           if (mCount < 255) mCount++;
         end
      1: if (stp) mState = 2; else if (res) mState = 3;
      2: if (valid) mState = 1;
      3: if (valid) mState = 0;
      default: mState = 0;
    endcase
    if (wrEn) begin
      mAddr[wrIdx]  = wrAddr & 'hFFF;
      mArmed[wrIdx] = wrArm;
    end
    #1;
  endtask

  task automatic issue(input int pc);
    runCycle(1'b0, 0, 0, 1'b0, pc, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic writeSlot(input int idx, input int addr, input logic arm);
    runCycle(1'b1, idx, addr, arm, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulseResume(input int pc);
    runCycle(1'b0, 0, 0, 1'b0, pc, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    modelReset();
    checkVal("rst_halt", 32'(halt), 0);
    checkRegs("rst");
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  int savedCount;
  int addrSet [4] = '{'h010, 'h020, 'h030, 'h040};

  initial begin
    bp_wr_en = 0; bp_wr_idx = 0; bp_wr_addr = 0; bp_wr_arm = 0;
    pc_in = 0; pc_valid = 0; resume = 0; step = 0;
    doReset();

    // Basic hit on slot 2
    writeSlot(2, 'h1A4, 1'b1);
    for (int pc = 'h1A0; pc <= 'h1A4; pc++) issue(pc);
    checkVal("tp1_halt", 32'(lastHalt), 1);
    checkVal("tp1_pulse", 32'(hit_pulse), 1);
    checkVal("tp1_idx", 32'(hit_idx), 2);
    checkVal("tp1_count", 32'(hit_count), 1);
    checkVal("tp1_state", 32'(dbg_state), 1);

    // Resume: breakpointed PC issues once, later visit halts again
    pulseResume('h1A4);
    checkVal("tp2_skip", 32'(dbg_state), 3);
    issue('h1A4);
    checkVal("tp2_nohalt", 32'(lastHalt), 0);
    checkVal("tp2_run", 32'(dbg_state), 0);
    issue('h1A8);
    issue('h1A4);
    checkVal("tp2_count", 32'(hit_count), 2);
    pulseResume('h1A4);
    issue('h1A4);

    // Lowest index wins
    writeSlot(0, 'h050, 1'b1);
    writeSlot(3, 'h050, 1'b1);
    issue('h050);
    checkVal("tp3_idx", 32'(hit_idx), 0);
    pulseResume('h050);
    issue('h050);

    // Step priority over resume; re-halt does not count
    writeSlot(1, 'h100, 1'b1);
    issue('h100);
    savedCount = int'(hit_count);
    runCycle(1'b0, 0, 0, 1'b0, 'h100, 1'b1, 1'b1, 1'b1);
    checkVal("tp4_step", 32'(dbg_state), 2);
    runCycle(1'b0, 0, 0, 1'b0, 'h100, 1'b0, 1'b0, 1'b0);
    checkVal("tp4_stephold", 32'(lastHalt), 0);
    issue('h104);
    checkVal("tp4_rehalt", 32'(dbg_state), 1);
    checkVal("tp4_pulse", 32'(hit_pulse), 0);
    checkVal("tp4_count", 32'(hit_count), 32'(savedCount));
    pulseResume('h104);
    issue('h104);

    // Same-cycle write uses old slot contents
    runCycle(1'b1, 1, 'h200, 1'b1, 'h200, 1'b1, 1'b0, 1'b0);
    checkVal("tp5_nohalt", 32'(lastHalt), 0);
    issue('h200);
    checkVal("tp5_halt", 32'(lastHalt), 1);
    pulseResume('h200);
    issue('h200);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      runCycle(($urandom_range(7) == 0), int'($urandom_range(NUM_BP - 1)),
               addrSet[$urandom_range(3)], 1'($urandom_range(1)),
               ($urandom_range(3) == 0) ? int'($urandom_range(4095)) : addrSet[$urandom_range(3)],
               ($urandom_range(3) != 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0));
    end

    // Counter saturation
    doReset();
    writeSlot(0, 'h300, 1'b1);
    for (int n = 1; n <= 256; n++) begin
      issue('h300);
      if (n == 255) checkVal("sat_255", 32'(hit_count), 'hFF);
      if (n == 256) checkVal("sat_256", 32'(hit_count), 'hFF);
      pulseResume('h300);
      issue('h300);
    end

    // Asynchronous reset while halted
    issue('h300);
    checkVal("ar_pre", 32'(dbg_state), 1);
    reset = 1'b0;
    #1;
    checkVal("ar_halt", 32'(halt), 0);
    checkVal("ar_armed", 32'(bp_armed), 0);
    checkVal("ar_state", 32'(dbg_state), 0);
    checkVal("ar_count", 32'(hit_count), 0);
    modelReset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    issue('h300);
    checkVal("ar_nohit", 32'(lastHalt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
